// File: rtl/rda_pipe_adder.sv
// rda_pipe_adder
// Fully pipelined Kogge-Stone (recursive-doubling) adder/subtractor.
// Each bit pair is classified as kill/propagate/generate. log2(WIDTH)
// doubling levels then resolve the carries, with one register stage per
// level. A final stage forms the sum. All stages advance together under a
// single global stall, so the block sustains one operation per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all stages)
//   in_valid   operand set presented
//   in_ready   pipeline can accept this cycle (combinational)
//   a, b       operands, WIDTH bits
//   cin        carry-in (ignored when sub=1)
//   sub        1: compute a-b
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result, WIDTH bits
//   cout       carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
module rda_pipe_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b01,
        GEN  = 2'b10
    } status_t;

    // Stage k (0..LEVELS) registers: 0 is the classify stage, k>0 holds the
    // status after doubling level k-1.
    logic             v_q   [0:LEVELS];
    logic [WIDTH-1:0] a_q   [0:LEVELS];
    logic [WIDTH-1:0] bp_q  [0:LEVELS];
    logic             c0_q  [0:LEVELS];
    status_t          st_q  [0:LEVELS][WIDTH];

    status_t          st_in [WIDTH];
    status_t          st_d  [LEVELS][WIDTH];
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH:0]   carry;
    logic             advance;

    // The whole pipeline moves whenever the output register is free or
    // being drained; otherwise everything holds.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1, so invert b and force the carry-in.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        for (int i = 0; i < WIDTH; i++) begin
            st_in[i] = PROP;
            if (a[i] & b_eff[i]) begin
                st_in[i] = GEN;
            end else if (~a[i] & ~b_eff[i]) begin
                st_in[i] = KILL;
            end
        end
    end

    // Doubling level j looks 2**j bits down. A propagate bit adopts the
    // status of that lower span; kill/generate are already final. Bits with
    // nothing below them at this distance pass through untouched.
    for (genvar j = 0; j < LEVELS; j++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << j)) begin : g_comb
                assign st_d[j][i] = (st_q[j][i] == PROP) ? st_q[j][i-(1<<j)]
                                                         : st_q[j][i];
            end else begin : g_pass
                assign st_d[j][i] = st_q[j][i];
            end
        end
    end

    // After the last level a remaining propagate means bits 0..i all
    // propagate, so the carry out of bit i is simply c0.
    always_comb begin
        carry    = '0;
        carry[0] = c0_q[LEVELS];
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = (st_q[LEVELS][i] == GEN) |
                         ((st_q[LEVELS][i] == PROP) & c0_q[LEVELS]);
        end
    end

    // All stage registers and valid bits load together on advance. Bubbles
    // travel as invalid stages; data registers load regardless of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                bp_q[k] <= '0;
                c0_q[k] <= 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    st_q[k][i] <= KILL;
                end
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            v_q[0]  <= in_valid;
            a_q[0]  <= a;
            bp_q[0] <= b_eff;
            c0_q[0] <= c0;
            st_q[0] <= st_in;
            for (int k = 0; k < LEVELS; k++) begin
                v_q[k+1]  <= v_q[k];
                a_q[k+1]  <= a_q[k];
                bp_q[k+1] <= bp_q[k];
                c0_q[k+1] <= c0_q[k];
                st_q[k+1] <= st_d[k];
            end
            out_valid <= v_q[LEVELS];
            sum       <= a_q[LEVELS] ^ bp_q[LEVELS] ^ carry[WIDTH-1:0];
            cout      <= carry[WIDTH];
            ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

endmodule
